// File: rtl/crypto_wallet2_prng_pkg.sv
// Shared constants, FSM state type and the xorshift64 step used by the seed PRNG.
package crypto_wallet2_prng_pkg;

    localparam int XS_A = 13;
    localparam int XS_B = 7;
    localparam int XS_C = 17;

    // Substituted for an all-zero seed, which is a fixed point of xorshift.
    localparam logic [63:0] ZERO_SEED_SUB = 64'h9E3779B97F4A7C15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WARMUP = 2'd2,
        RUN    = 2'd3
    } prng_state_e;

    function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << XS_A);
        t = t ^ (t >> XS_B);
        return t ^ (t << XS_C);
    endfunction

endpackage

// File: rtl/crypto_wallet2_prng_fifo.sv
// Small synchronous FIFO with flush; the output holds the last shown head word while empty.
module crypto_wallet2_prng_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_hold;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? r_hold : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (!o_empty) begin
                r_hold <= r_mem[r_rd_ptr];
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/crypto_wallet2_seed_prng.sv
// Seeded xorshift64 word source with warm-up discard and output FIFO.
// Optional PRNG_STUCK_DETECT_EN adds a sticky repeated-word health flag.
module crypto_wallet2_seed_prng
    import crypto_wallet2_prng_pkg::*;
#(
    parameter int WARMUP_ROUNDS = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] seed_high,
    input  logic [31:0] seed_low,
    input  logic        seed_load,
    output logic [31:0] rnd_data,
    output logic        rnd_valid,
    input  logic        rnd_ready,
    output logic        busy,
    output logic        stuck_err
);

    localparam int CW = (WARMUP_ROUNDS < 2) ? 1 : $clog2(WARMUP_ROUNDS + 1);

    prng_state_e r_state;
    prng_state_e w_state_nxt;
    logic [63:0] r_seed_q;
    logic [63:0] r_x;
    logic [CW-1:0] r_warm_cnt;
    logic [63:0] w_seed;
    logic [63:0] w_x_next;
    logic        w_req;
    logic        w_step_en;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;

    assign w_seed   = {seed_high, seed_low};
    assign w_req    = (w_seed != r_seed_q) || seed_load;
    assign w_x_next = xorshift64_step(r_x);
    assign w_pop    = rnd_valid && rnd_ready;
    assign rnd_valid = !w_empty;
    assign busy     = (r_state == LOAD) || (r_state == WARMUP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_en   = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: ;
            LOAD: w_state_nxt = (WARMUP_ROUNDS == 0) ? RUN : WARMUP;
            WARMUP: begin
                w_step_en = 1'b1;
                if (r_warm_cnt == CW'(1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step_en = !w_full || w_pop;
                w_push    = w_step_en;
            end
            default: w_state_nxt = IDLE;
        endcase
        // A reseed request overrides everything, in any state.
        if (w_req) begin
            w_state_nxt = LOAD;
            w_step_en   = 1'b0;
            w_push      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seed_q   <= '0;
            r_x        <= '0;
            r_warm_cnt <= '0;
        end else if (w_req) begin
            r_seed_q   <= w_seed;
            r_x        <= (w_seed == '0) ? ZERO_SEED_SUB : w_seed;
            r_warm_cnt <= CW'(WARMUP_ROUNDS);
        end else begin
            if (w_step_en) begin
                r_x <= w_x_next;
            end
            if (r_state == WARMUP) begin
                r_warm_cnt <= r_warm_cnt - CW'(1);
            end
        end
    end

    crypto_wallet2_prng_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_req),
        .i_data  (w_x_next[31:0]),
        .o_data  (rnd_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef PRNG_STUCK_DETECT_EN
    logic [31:0] r_prev_word;
    logic        r_prev_vld;
    logic        r_stuck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_word <= '0;
            r_prev_vld  <= 1'b0;
            r_stuck     <= 1'b0;
        end else if (w_req) begin
            r_prev_vld <= 1'b0;
        end else if (w_push) begin
            if (r_prev_vld && (w_x_next[31:0] == r_prev_word)) begin
                r_stuck <= 1'b1;
            end
            r_prev_word <= w_x_next[31:0];
            r_prev_vld  <= 1'b1;
        end
    end

    assign stuck_err = r_stuck;
`else
    assign stuck_err = 1'b0;
`endif

endmodule
